// File: rtl/dp_pkg.sv
// Shared types and sizing helpers for the dot product unit.
package dp_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  // Accumulator wide enough that LEN full-scale products never wrap.
  function automatic int acc_width(input int data_w, input int len);
    return 2 * data_w + $clog2(len);
  endfunction

endpackage

// File: rtl/dp_saturate.sv
// Combinational clamp of the accumulator into the result width.
module dp_saturate #(
  parameter int IN_W   = 11,
  parameter int OUT_W  = 12,
  parameter int SIGNED = 0
) (
  input  logic [IN_W-1:0]  acc,
  output logic [OUT_W-1:0] value,
  output logic             ovf
);

  if (OUT_W >= IN_W) begin : g_ext
    if (SIGNED != 0) begin : g_sx
      assign value = OUT_W'($signed(acc));
    end else begin : g_zx
      assign value = OUT_W'(acc);
    end
    assign ovf = 1'b0;
  end else if (SIGNED != 0) begin : g_sclamp
    localparam int HW = IN_W - OUT_W + 1;
    logic [HW-1:0] hi;
    assign hi  = acc[IN_W-1:OUT_W-1];
    // In range only when all dropped bits match the new sign bit.
    assign ovf = !((&hi) || !(|hi));
    assign value = ovf
      ? {acc[IN_W-1], {(OUT_W-1){~acc[IN_W-1]}}}
      : acc[OUT_W-1:0];
  end else begin : g_uclamp
    assign ovf   = |acc[IN_W-1:OUT_W];
    assign value = ovf ? '1 : acc[OUT_W-1:0];
  end

endmodule

// File: rtl/dot_product_unit.sv
// Streaming dot product: one operand pair per handshake,
// LEN pairs per result, saturated into OUT_W bits.
module dot_product_unit
  import dp_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int LEN    = 8,
  parameter int OUT_W  = 12,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              busy
);

  localparam int ACC_W = acc_width(DATA_W, LEN);
  localparam int PW    = 2 * DATA_W;
  localparam int CW    = $clog2(LEN);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   count;
  logic [PW-1:0]   mul;
  logic [PW-1:0]   prod;
  logic            prod_vld;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod_ext;
  logic [OUT_W-1:0] sat_val;
  logic            sat_ovf;
  logic            hs_in;
  logic            hs_out;
  logic            last;

  assign hs_in  = in_valid && in_ready;
  assign hs_out = out_valid && out_ready;
  assign last   = count == CW'(LEN - 1);

  if (SIGNED != 0) begin : g_smul
    assign mul      = $signed(a) * $signed(b);
    assign prod_ext = {{CW{prod[PW-1]}}, prod};
  end else begin : g_umul
    assign mul      = a * b;
    assign prod_ext = {{CW{1'b0}}, prod};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM: if (hs_in && last) state_nx = DRAIN;
      DRAIN: state_nx = HOLD;
      HOLD:  if (out_ready) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = rst && (state == ACCUM);
    out_valid = state == HOLD;
    busy      = (count != '0) || (state != ACCUM);
    out_data  = out_valid ? sat_val : '0;
    out_ovf   = out_valid && sat_ovf;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= hs_in;
      if (hs_in) begin
        prod  <= mul;
        count <= last ? '0 : count + 1'b1;
      end
      if (prod_vld) acc <= acc + prod_ext;
      if (hs_out) begin
        acc   <= '0;
        count <= '0;
      end
    end
  end

  dp_saturate #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SIGNED(SIGNED)
  ) u_sat (
    .acc  (acc),
    .value(sat_val),
    .ovf  (sat_ovf)
  );

endmodule

// File: tb/tb_dot_product_unit.sv
// Directed bench for dot_product_unit: default, LEN=32 and
// signed instances driven from a vector table plus corner sequences.
module tb_dot_product_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       in_valid;
  logic [2:0]       in_ready;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [2:0]       out_ovf;
  logic [2:0]       busy;
  logic [2:0][3:0]  a;
  logic [2:0][3:0]  b;
  logic [2:0][11:0] od;

  dot_product_unit u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(od[0]), .out_ovf(out_ovf[0]), .busy(busy[0])
  );

  dot_product_unit #(.LEN(32)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(od[1]), .out_ovf(out_ovf[1]), .busy(busy[1])
  );

  dot_product_unit #(.SIGNED(1)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(od[2]), .out_ovf(out_ovf[2]), .busy(busy[2])
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  typedef struct {
    int d;
    int av;
    int bv;
    int n;
    bit ramp;
    int gap;
    int exp_data;
    int exp_ovf;
  } vec_t;

  vec_t vt[6];

  task automatic burst(input int d, input int av, input int bv,
                       input int n, input bit ramp, input int gap);
    int k;
    for (int i = 0; i < n; i++) begin
      k = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
      for (int j = 0; j < k; j++) begin
        in_valid[d] = 1'b0;
        @(negedge clk);
      end
      a[d] = 4'(ramp ? i + 1 : av);
      b[d] = 4'(bv);
      in_valid[d] = 1'b1;
      if (i == 0) chk("in_ready_accum", int'(in_ready[d]), 1);
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
  endtask

  // Entered one half-cycle after the last input handshake.
  task automatic finish_run(input int d, input int exp_data,
                            input int exp_ovf);
    chk("drain_out_valid", int'(out_valid[d]), 0);
    chk("drain_in_ready", int'(in_ready[d]), 0);
    chk("drain_busy", int'(busy[d]), 1);
    @(negedge clk);
    chk("hold_out_valid", int'(out_valid[d]), 1);
    chk("out_data", int'(od[d]), exp_data);
    chk("out_ovf", int'(out_ovf[d]), exp_ovf);
    chk("hold_in_ready", int'(in_ready[d]), 0);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk("post_out_valid", int'(out_valid[d]), 0);
    chk("post_in_ready", int'(in_ready[d]), 1);
    chk("post_busy", int'(busy[d]), 0);
  endtask

  initial begin
    in_valid  = '0;
    out_ready = '0;
    a = '0;
    b = '0;

    vt[0] = '{d:0, av:15, bv:15, n:8,  ramp:0, gap:0, exp_data:1800,   exp_ovf:0};
    vt[1] = '{d:1, av:15, bv:15, n:32, ramp:0, gap:0, exp_data:4095,   exp_ovf:1};
    vt[2] = '{d:2, av:-8, bv:7,  n:8,  ramp:0, gap:0, exp_data:'hE40,  exp_ovf:0};
    vt[3] = '{d:2, av:-8, bv:-8, n:8,  ramp:0, gap:0, exp_data:512,    exp_ovf:0};
    vt[4] = '{d:0, av:0,  bv:1,  n:8,  ramp:1, gap:3, exp_data:36,     exp_ovf:0};
    vt[5] = '{d:0, av:10, bv:12, n:8,  ramp:0, gap:1, exp_data:960,    exp_ovf:0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready[0]), 0);
    chk("rst_out_valid", int'(out_valid[0]), 0);
    chk("rst_out_data", int'(od[0]), 0);
    chk("rst_out_ovf", int'(out_ovf[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    rst = 1'b1;
    #1;
    chk("rst_release_in_ready", int'(in_ready[0]), 1);
    @(negedge clk);

    foreach (vt[i]) begin
      burst(vt[i].d, vt[i].av, vt[i].bv, vt[i].n, vt[i].ramp, vt[i].gap);
      finish_run(vt[i].d, vt[i].exp_data, vt[i].exp_ovf);
    end

    // Result held while the consumer stalls; inputs offered meanwhile.
    burst(0, 2, 3, 8, 1'b0, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      a[0] = 4'd15;
      b[0] = 4'd15;
      in_valid[0] = 1'b1;
      chk("stall_out_valid", int'(out_valid[0]), 1);
      chk("stall_out_data", int'(od[0]), 48);
      chk("stall_out_ovf", int'(out_ovf[0]), 0);
      chk("stall_in_ready", int'(in_ready[0]), 0);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    chk("hs_in_ready", int'(in_ready[0]), 0);
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    chk("hs_no_accept_busy", int'(busy[0]), 0);
    burst(0, 1, 1, 8, 1'b0, 0);
    finish_run(0, 8, 0);

    // Reset in the middle of a run discards the partial sum.
    burst(0, 3, 3, 5, 1'b0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(in_ready[0]), 0);
    chk("mid_rst_out_valid", int'(out_valid[0]), 0);
    chk("mid_rst_out_data", int'(od[0]), 0);
    chk("mid_rst_out_ovf", int'(out_ovf[0]), 0);
    chk("mid_rst_busy", int'(busy[0]), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_release_ready", int'(in_ready[0]), 1);
    @(negedge clk);
    burst(0, 1, 1, 8, 1'b0, 0);
    finish_run(0, 8, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dot_product_unit.md
DOT_PRODUCT_UNIT -- requirements
Module: dot_product_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 4, operand width in bits.
REQ-002 SHALL have parameter LEN, default 8, number of element pairs per dot product (LEN >= 2).
REQ-003 SHALL have parameter OUT_W, default 12, result width in bits.
REQ-004 SHALL have parameter SIGNED, default 0; 0 means unsigned operands, 1 means two's-complement operands.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, operand pair valid.
REQ-008 SHALL have port in_ready, output, 1, unit accepts an operand pair.
REQ-009 SHALL have ports a and b, input, DATA_W each, operands.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port out_data, output, OUT_W, saturated dot product.
REQ-013 SHALL have port out_ovf, output, 1, out_data was clamped.
REQ-014 SHALL have port busy, output, 1, a dot product is in progress (count > 0, or state DRAIN or HOLD).

Function
REQ-015 SHALL run the states ACCUM, DRAIN and HOLD.
REQ-016 SHALL, in ACCUM, drive in_ready=1; an input handshake occurs when in_valid && in_ready.
REQ-017 SHALL, on each handshake, register the product a*b (2*DATA_W bits, signedness per SIGNED) together with a product-valid flag.
REQ-018 SHALL add the product to the accumulator exactly one cycle after its handshake.
REQ-019 SHALL size the accumulator at ACC_W = 2*DATA_W + clog2(LEN) bits so that it never wraps internally.
REQ-020 SHALL ignore cycles with in_valid=0: no accumulation occurs and the element count is unchanged.
REQ-021 SHALL count handshakes from 0 to LEN-1; the LEN-th handshake moves ACCUM to DRAIN and drops in_ready in the following cycle.
REQ-022 SHALL, in DRAIN, drive in_ready=0 for exactly one cycle while the final product is accumulated, then move to HOLD.
REQ-023 SHALL, in HOLD, drive out_valid=1 and keep out_data and out_ovf stable until out_ready=1.
REQ-024 SHALL, on an output handshake, clear the accumulator and the count and return to ACCUM in the next cycle.
REQ-025 SHALL drive in_ready=0 throughout HOLD, including the handshake cycle, so a simultaneous in_valid is not accepted.
REQ-026 SHALL assert out_valid in cycle t+2 when the last input handshake occurs in cycle t.
REQ-027 SHALL apply output saturation: if SIGNED=0, clamp to [0, 2^OUT_W-1]; if SIGNED=1, clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-028 SHALL set out_ovf=1 if and only if a clamp occurred.
REQ-029 SHALL, when OUT_W >= ACC_W, sign- or zero-extend the accumulator (per SIGNED), with out_ovf always 0.

Reset
REQ-030 SHALL, when rst=0 at a clock edge, put the unit in ACCUM with count=0, accumulator=0, product-valid=0, out_valid=0, out_data=0, out_ovf=0 and busy=0.
REQ-031 SHALL drive in_ready=0 while rst=0, and drive in_ready=1 in the first cycle after rst returns to 1.
REQ-032 SHALL, on reset mid-operation (any state), discard the partial sum and any held result, and emit no output.

Structure
REQ-033 SHALL place the state enum (ACCUM/DRAIN/HOLD) and the accumulator-width function (ACC_W derivation) in the shared package dp_pkg.
REQ-034 SHALL implement clamping in one sub-module dp_saturate (parameters IN_W, OUT_W, SIGNED; combinational; outputs value and ovf).
REQ-035 SHALL contain no other sub-modules; the multiplier and accumulator are inline registers.

Verification
REQ-036 SHALL cover: defaults, 8 pairs a=15,b=15, in_valid held 1 -> out_data=1800, out_ovf=0, out_valid 2 cycles after the 8th handshake.
REQ-037 SHALL cover: LEN=32, all pairs 15*15 -> out_data=4095, out_ovf=1.
REQ-038 SHALL cover: SIGNED=1, 8 pairs a=-8,b=7 -> out_data=-448 (12'hE40); then 8 pairs a=-8,b=-8 -> out_data=512.
REQ-039 SHALL cover: in_valid gaps of 0-3 random cycles between pairs of 1..8 x 1 -> out_data=36, no extra accumulation.
REQ-040 SHALL cover: out_ready held 0 for 5 cycles in HOLD -> out_valid, out_data and out_ovf stable, in_ready=0, and an in_valid presented during HOLD is not consumed.
REQ-041 SHALL cover: rst=0 after 5 of 8 pairs -> all outputs 0; a fresh 8-pair run of 1*1 -> out_data=8.
